// File: rtl/xup_debounce_pulse_pkg.sv
// xup_debounce_pulse_pkg: debouncer state encoding and default cycle constants for a 100 MHz clock
package xup_debounce_pulse_pkg;
  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;
  localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
  localparam int DEF_REPEAT_DELAY    = 50_000_000;
  localparam int DEF_REPEAT_RATE     = 10_000_000;
  localparam int DEF_CNT_WIDTH       = 26;
endpackage

// File: rtl/xup_debounce_pulse_sync_2ff.sv
// xup_sync_2ff: two-flop synchronizer with asynchronous active-low clear
module xup_sync_2ff (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);
  logic m;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) {q, m} <= 2'b00;
    else {q, m} <= {m, d};
endmodule

// File: rtl/xup_debounce_pulse.sv
// xup_debounce_pulse: debounced level and one-cycle press strobe from a bouncing button
// Define XUP_DEBOUNCE_AUTOREPEAT_EN to add auto-repeat pulses while the button is held.
module xup_debounce_pulse
  import xup_debounce_pulse_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE     = DEF_REPEAT_RATE,
  parameter int CNT_WIDTH       = DEF_CNT_WIDTH
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_in,
  output logic level,
  output logic press_pulse
);
  localparam logic [CNT_WIDTH-1:0] DB_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
`ifdef XUP_DEBOUNCE_AUTOREPEAT_EN
  localparam logic [CNT_WIDTH-1:0] DELAY_LAST = CNT_WIDTH'(REPEAT_DELAY - 1);
  localparam logic [CNT_WIDTH-1:0] RATE_LAST  = CNT_WIDTH'(REPEAT_RATE - 1);
`endif
  if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1 ||
      DEBOUNCE_CYCLES > 2**CNT_WIDTH - 1 || REPEAT_DELAY > 2**CNT_WIDTH - 1 ||
      REPEAT_RATE > 2**CNT_WIDTH - 1) begin : g_bad_params
    $error("xup_debounce_pulse: cycle parameter out of range");
  end
  state_t state, state_nx;
  logic [CNT_WIDTH-1:0] cnt, cnt_nx;
  logic btn_s, rep, rep_nx, pulse_nx;
  xup_sync_2ff u_sync (.clk(clk), .reset_n(reset_n), .d(btn_in), .q(btn_s));
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      rep         <= 1'b0;
      level       <= 1'b0;
      press_pulse <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      rep         <= rep_nx;
      level       <= state_nx == PRESSED || state_nx == RELEASE_WAIT;
      press_pulse <= pulse_nx;
    end
  // rep marks that the first repeat has fired, so later ones use REPEAT_RATE
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    rep_nx   = rep;
    pulse_nx = 1'b0;
    case (state)
      IDLE: if (btn_s) begin
        state_nx = PRESS_WAIT;
        cnt_nx   = '0;
      end
      PRESS_WAIT:
        if (!btn_s) state_nx = IDLE;
        else if (cnt == DB_LAST) begin
          state_nx = PRESSED;
          cnt_nx   = '0;
          rep_nx   = 1'b0;
          pulse_nx = 1'b1;
        end else cnt_nx = cnt + 1'b1;
      PRESSED:
        if (!btn_s) begin
          state_nx = RELEASE_WAIT;
          cnt_nx   = '0;
        end
`ifdef XUP_DEBOUNCE_AUTOREPEAT_EN
        else if (cnt == (rep ? RATE_LAST : DELAY_LAST)) begin
          cnt_nx   = '0;
          rep_nx   = 1'b1;
          pulse_nx = 1'b1;
        end else cnt_nx = cnt + 1'b1;
`endif
      RELEASE_WAIT:
        if (btn_s) begin
          state_nx = PRESSED;
          cnt_nx   = '0;
          rep_nx   = 1'b0;
        end else if (cnt == DB_LAST) state_nx = IDLE;
        else cnt_nx = cnt + 1'b1;
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
        rep_nx   = 1'b0;
      end
    endcase
  end
endmodule

// File: tb/tb_xup_debounce_pulse.sv
// tb_xup_debounce_pulse: directed checks of debounce timing, bounce rejection, reset and a downstream enabled register
module tb_xup_debounce_pulse;
  logic clk = 1'b0, reset_n = 1'b0, btn_in = 1'b0;
  logic level, press_pulse;
  logic [3:0] q;
  int loads = 0, checks = 0, errors = 0;

  xup_debounce_pulse #(.DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_RATE(3), .CNT_WIDTH(8)) dut (
    .clk(clk), .reset_n(reset_n), .btn_in(btn_in), .level(level), .press_pulse(press_pulse));

  always #5 clk = ~clk;

  // Downstream enabled 4-bit register with d=4'hA; loads counts its enabled edges
  always @(posedge clk or negedge reset_n)
    if (!reset_n) q <= 4'h0;
    else if (press_pulse) begin
      q <= 4'hA;
      loads <= loads + 1;
    end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    reset_n = 1'b0; btn_in = 1'b1; step(3);
    checks++; if ({level, press_pulse} !== 2'b00) begin errors++; $display("FAIL reset_hold: {level,pulse}=%b want 00", {level, press_pulse}); end
    reset_n = 1'b1; step(6);
    checks++; if ({level, press_pulse} !== 2'b00) begin errors++; $display("FAIL reset_requal_early: {level,pulse}=%b want 00", {level, press_pulse}); end
    step(1);
    checks++; if ({level, press_pulse} !== 2'b11) begin errors++; $display("FAIL reset_requal_rise: {level,pulse}=%b want 11", {level, press_pulse}); end
    step(1);
    checks++; if ({level, press_pulse} !== 2'b10) begin errors++; $display("FAIL reset_pulse_width: {level,pulse}=%b want 10", {level, press_pulse}); end
    btn_in = 1'b0; step(6);
    checks++; if ({level, press_pulse} !== 2'b10) begin errors++; $display("FAIL release_early: {level,pulse}=%b want 10", {level, press_pulse}); end
    step(1);
    checks++; if ({level, press_pulse} !== 2'b00) begin errors++; $display("FAIL release_fall: {level,pulse}=%b want 00", {level, press_pulse}); end
  endtask

  task automatic test_clean_press;
    int base = loads;
    btn_in = 1'b1; step(6);
    checks++; if ({level, press_pulse} !== 2'b00) begin errors++; $display("FAIL press_early: {level,pulse}=%b want 00", {level, press_pulse}); end
    step(1);
    checks++; if ({level, press_pulse} !== 2'b11) begin errors++; $display("FAIL press_rise: {level,pulse}=%b want 11", {level, press_pulse}); end
    step(1);
    checks++; if ({level, press_pulse} !== 2'b10) begin errors++; $display("FAIL press_width: {level,pulse}=%b want 10", {level, press_pulse}); end
    btn_in = 1'b0; step(8);
    checks++; if ({level, press_pulse} !== 2'b00) begin errors++; $display("FAIL press_release: {level,pulse}=%b want 00", {level, press_pulse}); end
    checks++; if (loads - base !== 1) begin errors++; $display("FAIL press_count: got %0d pulses want 1", loads - base); end
  endtask

  task automatic test_bounce;
    int base = loads;
    for (int g = 1; g <= 3; g++) begin
      btn_in = 1'b1; step(g); btn_in = 1'b0; step(5);
      checks++; if (level !== 1'b0) begin errors++; $display("FAIL bounce_high_%0d: level=%b want 0", g, level); end
    end
    step(4);
    checks++; if (loads - base !== 0) begin errors++; $display("FAIL bounce_high_count: got %0d pulses want 0", loads - base); end
    btn_in = 1'b1; step(8);
    base = loads;
    for (int g = 1; g <= 3; g++) begin
      btn_in = 1'b0; step(g); btn_in = 1'b1; step(5);
      checks++; if (level !== 1'b1) begin errors++; $display("FAIL bounce_low_%0d: level=%b want 1", g, level); end
    end
    checks++; if (loads - base !== 0) begin errors++; $display("FAIL bounce_low_count: got %0d pulses want 0", loads - base); end
    btn_in = 1'b0; step(8);
    checks++; if (level !== 1'b0) begin errors++; $display("FAIL bounce_release: level=%b want 0", level); end
  endtask

`ifdef XUP_DEBOUNCE_AUTOREPEAT_EN
  task automatic test_auto_repeat;
    btn_in = 1'b1; step(7);
    checks++; if ({level, press_pulse} !== 2'b11) begin errors++; $display("FAIL repeat_press: {level,pulse}=%b want 11", {level, press_pulse}); end
    for (int j = 1; j <= 31; j++) begin
      step(1);
      checks++; if (press_pulse !== (j >= 10 && (j - 10) % 3 == 0)) begin errors++; $display("FAIL repeat_at_%0d: pulse=%b want %b", j, press_pulse, j >= 10 && (j - 10) % 3 == 0); end
    end
    btn_in = 1'b0; step(1); btn_in = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      step(1);
      checks++; if (press_pulse !== (i == 13)) begin errors++; $display("FAIL repeat_restart_%0d: pulse=%b want %b", i, press_pulse, i == 13); end
    end
    btn_in = 1'b0; step(8);
  endtask
`else
  task automatic test_no_repeat;
    int base = loads;
    btn_in = 1'b1; step(7);
    checks++; if ({level, press_pulse} !== 2'b11) begin errors++; $display("FAIL hold_press: {level,pulse}=%b want 11", {level, press_pulse}); end
    step(30);
    checks++; if ({level, press_pulse} !== 2'b10) begin errors++; $display("FAIL hold_level: {level,pulse}=%b want 10", {level, press_pulse}); end
    checks++; if (loads - base !== 1) begin errors++; $display("FAIL hold_count: got %0d pulses want 1", loads - base); end
    btn_in = 1'b0; step(8);
  endtask
`endif

  task automatic test_mid_reset;
    btn_in = 1'b1; step(4); #2 reset_n = 1'b0; #1;
    checks++; if ({level, press_pulse} !== 2'b00) begin errors++; $display("FAIL midrst_wait: {level,pulse}=%b want 00", {level, press_pulse}); end
    @(negedge clk) reset_n = 1'b1; step(6);
    checks++; if ({level, press_pulse} !== 2'b00) begin errors++; $display("FAIL midrst_requal_early: {level,pulse}=%b want 00", {level, press_pulse}); end
    step(1);
    checks++; if ({level, press_pulse} !== 2'b11) begin errors++; $display("FAIL midrst_requal_rise: {level,pulse}=%b want 11", {level, press_pulse}); end
    #2 reset_n = 1'b0; #1;
    checks++; if ({level, press_pulse, q} !== 6'b00_0000) begin errors++; $display("FAIL midrst_pulse: {level,pulse,q}=%b want 000000", {level, press_pulse, q}); end
    @(negedge clk) reset_n = 1'b1; step(6);
    checks++; if ({level, press_pulse} !== 2'b00) begin errors++; $display("FAIL midrst2_early: {level,pulse}=%b want 00", {level, press_pulse}); end
    step(1);
    checks++; if ({level, press_pulse} !== 2'b11) begin errors++; $display("FAIL midrst2_rise: {level,pulse}=%b want 11", {level, press_pulse}); end
    btn_in = 1'b0; step(8);
  endtask

  task automatic test_chain;
    int base;
    reset_n = 1'b0; step(1);
    checks++; if (q !== 4'h0) begin errors++; $display("FAIL chain_reset: q=%h want 0", q); end
    reset_n = 1'b1; base = loads;
    btn_in = 1'b1; step(10);
    checks++; if (q !== 4'hA) begin errors++; $display("FAIL chain_load: q=%h want a", q); end
    checks++; if (loads - base !== 1) begin errors++; $display("FAIL chain_once: got %0d loads want 1", loads - base); end
    btn_in = 1'b0; step(8); btn_in = 1'b1; step(10); btn_in = 1'b0; step(8);
    checks++; if (loads - base !== 2) begin errors++; $display("FAIL chain_twice: got %0d loads want 2", loads - base); end
  endtask

  initial begin
    test_reset;
    test_clean_press;
    test_bounce;
`ifdef XUP_DEBOUNCE_AUTOREPEAT_EN
    test_auto_repeat;
`else
    test_no_repeat;
`endif
    test_mid_reset;
    test_chain;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
